// File: rtl/multicycle_controller.sv
// Main control FSM for a multi-cycle MIPS datapath: sequences one
// instruction through fetch/decode/execute/memory/writeback over a
// shared ALU and a single memory port, stalling memory steps on memReady.
//
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   instruction[5:0]   - opcode field from the instruction register
//   memReady           - memory completes the current access this cycle
//   pcWrite..pcSource  - datapath control word (Moore, decoded from state)
//   state[3:0]         - current FSM state for debug
//   illegalOp          - one-cycle pulse on an undecodable opcode in DECODE
//   retiredCount       - completed-instruction counter, wraps
module multicycle_controller #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [5:0]             instruction,
   input  logic                   memReady,
   output logic                   pcWrite,
   output logic                   pcWriteCond,
   output logic                   iorD,
   output logic                   memRead,
   output logic                   memWrite,
   output logic                   irWrite,
   output logic                   memToReg,
   output logic                   regDst,
   output logic                   regWrite,
   output logic                   aluSrcA,
   output logic [1:0]             aluSrcB,
   output logic [1:0]             aluOp,
   output logic [1:0]             pcSource,
   output logic [3:0]             state,
   output logic                   illegalOp,
   output logic [COUNT_WIDTH-1:0] retiredCount
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_ADDIEXEC = 4'd8,
      S_ADDIWB   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU-control encoding shared with the existing ALU decoder
   localparam logic [1:0] ALU_FUNCT = 2'd1;
   localparam logic [1:0] ALU_ADD   = 2'd2;
   localparam logic [1:0] ALU_SUB   = 2'd3;

   state_t                 state_q;
   state_t                 state_d;
   logic [COUNT_WIDTH-1:0] retired_q;
   logic [COUNT_WIDTH-1:0] retired_d;
   logic                   retire;
   logic                   illegal;

   // Next-state and retirement decode
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      illegal = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (memReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            unique case (instruction)
               OP_RTYPE: state_d = S_EXECUTE;
               OP_ADDI:  state_d = S_ADDIEXEC;
               OP_LW:    state_d = S_MEMADR;
               OP_SW:    state_d = S_MEMADR;
               OP_BEQ:   state_d = S_BRANCH;
               OP_J:     state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            if (instruction == OP_LW)
               state_d = S_MEMREAD;
            else if (instruction == OP_SW)
               state_d = S_MEMWRITE;
            else
               state_d = S_FETCH;
         end
         S_MEMREAD: begin
            if (memReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            if (memReady) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTE:  state_d = S_ALUWB;
         S_ALUWB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_ADDIEXEC: state_d = S_ADDIWB;
         S_ADDIWB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      retired_d = retire ? retired_q + COUNT_WIDTH'(1) : retired_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Moore control word; FETCH alone also looks at memReady so the IR and
   // PC load in the same cycle the read completes.
   always_comb begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      unique case (state_q)
         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            aluOp   = ALU_ADD;
            irWrite = memReady;
            pcWrite = memReady;
         end
         S_DECODE: begin
            aluSrcB = 2'b11;
            aluOp   = ALU_ADD;
         end
         S_MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            aluOp   = ALU_ADD;
         end
         S_MEMREAD: begin
            iorD    = 1'b1;
            memRead = 1'b1;
         end
         S_MEMWB: begin
            memToReg = 1'b1;
            regWrite = 1'b1;
         end
         S_MEMWRITE: begin
            iorD     = 1'b1;
            memWrite = 1'b1;
         end
         S_EXECUTE: begin
            aluSrcA = 1'b1;
            aluOp   = ALU_FUNCT;
         end
         S_ALUWB: begin
            regDst   = 1'b1;
            regWrite = 1'b1;
         end
         S_ADDIEXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            aluOp   = ALU_ADD;
         end
         S_ADDIWB: begin
            regWrite = 1'b1;
         end
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = ALU_SUB;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
         end
         S_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = 2'b10;
         end
         default: ;
      endcase
      // Reset kills any in-flight memory request immediately
      if (reset) begin
         pcWrite     = 1'b0;
         pcWriteCond = 1'b0;
         iorD        = 1'b0;
         memRead     = 1'b0;
         memWrite    = 1'b0;
         irWrite     = 1'b0;
         memToReg    = 1'b0;
         regDst      = 1'b0;
         regWrite    = 1'b0;
         aluSrcA     = 1'b0;
         aluSrcB     = 2'b00;
         aluOp       = 2'b00;
         pcSource    = 2'b00;
      end
   end

   assign state        = reset ? 4'd0 : state_q;
   assign illegalOp    = illegal & ~reset;
   assign retiredCount = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a 32-bit and a 4-bit
// counter instance share stimulus; each cycle's expectation is queued.
module tb_multicycle_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  instruction;
   logic        memReady;

   logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic        memToReg, regDst, regWrite, aluSrcA;
   logic [1:0]  aluSrcB, aluOp, pcSource;
   logic [3:0]  state;
   logic        illegalOp;
   logic [31:0] retiredCount;

   logic        b_pcWrite, b_pcWriteCond, b_iorD, b_memRead, b_memWrite;
   logic        b_irWrite, b_memToReg, b_regDst, b_regWrite, b_aluSrcA;
   logic [1:0]  b_aluSrcB, b_aluOp, b_pcSource;
   logic [3:0]  b_state;
   logic        b_illegalOp;
   logic [3:0]  b_retiredCount;

   always #5 clock = ~clock;

   multicycle_controller dut (
      .clock(clock), .reset(reset), .instruction(instruction),
      .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
      .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
      .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluOp(aluOp), .pcSource(pcSource), .state(state),
      .illegalOp(illegalOp), .retiredCount(retiredCount)
   );

   multicycle_controller #(.COUNT_WIDTH(4)) dut4 (
      .clock(clock), .reset(reset), .instruction(instruction),
      .memReady(memReady), .pcWrite(b_pcWrite),
      .pcWriteCond(b_pcWriteCond), .iorD(b_iorD), .memRead(b_memRead),
      .memWrite(b_memWrite), .irWrite(b_irWrite),
      .memToReg(b_memToReg), .regDst(b_regDst), .regWrite(b_regWrite),
      .aluSrcA(b_aluSrcA), .aluSrcB(b_aluSrcB), .aluOp(b_aluOp),
      .pcSource(b_pcSource), .state(b_state), .illegalOp(b_illegalOp),
      .retiredCount(b_retiredCount)
   );

   typedef struct {
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        ill;
      logic [31:0] c32;
      logic [3:0]  c4;
      logic        cnt_ok;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] cnt32;
   logic [3:0]  cnt4;
   logic        cnt_known = 1'b0;

   wire [15:0] got_ctl = {pcWrite, pcWriteCond, iorD, memRead,
                          memWrite, irWrite, memToReg, regDst,
                          regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected control word:
   // {pcW,pcWC,iorD,mRd,mWr,irW,m2r,rDst,rW,srcA,srcB,aluOp,pcSrc}
   function automatic logic [15:0] exp_ctl(input logic [3:0] st,
                                           input logic rdy);
      case (st)
         4'd0:  return {rdy, 2'b00, 1'b1, 1'b0, rdy, 4'b0000,
                       2'b01, 2'd2, 2'b00};
         4'd1:  return {10'b0, 2'b11, 2'd2, 2'b00};
         4'd2:  return {9'b0, 1'b1, 2'b10, 2'd2, 2'b00};
         4'd3:  return {2'b00, 2'b11, 12'b0};
         4'd4:  return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
         4'd5:  return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
         4'd6:  return {9'b0, 1'b1, 2'b00, 2'd1, 2'b00};
         4'd7:  return {7'b0, 2'b11, 7'b0};
         4'd8:  return {9'b0, 1'b1, 2'b10, 2'd2, 2'b00};
         4'd9:  return {8'b0, 1'b1, 7'b0};
         4'd10: return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'd3, 2'b01};
         4'd11: return {1'b1, 13'b0, 2'b10};
         default: return 16'h0;
      endcase
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom);
   endfunction

   // One clock cycle: drive inputs, queue expectation, compare mid-cycle
   task automatic cyc(input logic [3:0] st, input logic rdy,
                      input logic [5:0] op, input logic ill,
                      input logic ret);
      exp_t e;
      memReady    = rdy;
      instruction = op;
      e.st     = reset ? 4'd0 : st;
      e.ctl    = reset ? 16'h0 : exp_ctl(st, rdy);
      e.ill    = ill & ~reset;
      e.c32    = cnt32;
      e.c4     = cnt4;
      e.cnt_ok = cnt_known;
      sbq.push_back(e);
      @(negedge clock);
      e = sbq.pop_front();
      chk("state", {28'b0, state}, {28'b0, e.st});
      chk("ctl", {16'b0, got_ctl}, {16'b0, e.ctl});
      chk("illegalOp", {31'b0, illegalOp}, {31'b0, e.ill});
      chk("state4", {28'b0, b_state}, {28'b0, e.st});
      if (e.cnt_ok) begin
         chk("retired32", retiredCount, e.c32);
         chk("retired4", {28'b0, b_retiredCount}, {28'b0, e.c4});
      end
      @(posedge clock);
      #1;
      if (reset) begin
         cnt32     = 32'd0;
         cnt4      = 4'd0;
         cnt_known = 1'b1;
      end else if (ret) begin
         cnt32 = cnt32 + 32'd1;
         cnt4  = cnt4 + 4'd1;
      end
   endtask

   // Full instruction with fw FETCH stalls and mw memory-step stalls
   task automatic run(input logic [5:0] op, input int fw, input int mw);
      for (int i = 0; i < fw; i++) cyc(4'd0, 1'b0, rnd_op(), 1'b0, 1'b0);
      cyc(4'd0, 1'b1, rnd_op(), 1'b0, 1'b0);
      case (op)
         6'b000000: begin
            cyc(4'd1, rnd_bit(), op, 1'b0, 1'b0);
            cyc(4'd6, rnd_bit(), rnd_op(), 1'b0, 1'b0);
            cyc(4'd7, rnd_bit(), rnd_op(), 1'b0, 1'b1);
         end
         6'b001000: begin
            cyc(4'd1, rnd_bit(), op, 1'b0, 1'b0);
            cyc(4'd8, rnd_bit(), rnd_op(), 1'b0, 1'b0);
            cyc(4'd9, rnd_bit(), rnd_op(), 1'b0, 1'b1);
         end
         6'b100011: begin
            cyc(4'd1, rnd_bit(), op, 1'b0, 1'b0);
            cyc(4'd2, rnd_bit(), op, 1'b0, 1'b0);
            for (int i = 0; i < mw; i++)
               cyc(4'd3, 1'b0, rnd_op(), 1'b0, 1'b0);
            cyc(4'd3, 1'b1, rnd_op(), 1'b0, 1'b0);
            cyc(4'd4, rnd_bit(), rnd_op(), 1'b0, 1'b1);
         end
         6'b101011: begin
            cyc(4'd1, rnd_bit(), op, 1'b0, 1'b0);
            cyc(4'd2, rnd_bit(), op, 1'b0, 1'b0);
            for (int i = 0; i < mw; i++)
               cyc(4'd5, 1'b0, rnd_op(), 1'b0, 1'b0);
            cyc(4'd5, 1'b1, rnd_op(), 1'b0, 1'b1);
         end
         6'b000100: begin
            cyc(4'd1, rnd_bit(), op, 1'b0, 1'b0);
            cyc(4'd10, rnd_bit(), rnd_op(), 1'b0, 1'b1);
         end
         6'b000010: begin
            cyc(4'd1, rnd_bit(), op, 1'b0, 1'b0);
            cyc(4'd11, rnd_bit(), rnd_op(), 1'b0, 1'b1);
         end
         default: cyc(4'd1, rnd_bit(), op, 1'b1, 1'b0);
      endcase
   endtask

   initial begin
      cnt32       = 32'd0;
      cnt4        = 4'd0;
      reset       = 1'b1;
      memReady    = 1'b0;
      instruction = 6'd0;
      cyc(4'd0, 1'b1, rnd_op(), 1'b0, 1'b0);
      cyc(4'd0, 1'b1, rnd_op(), 1'b0, 1'b0);
      reset = 1'b0;

      run(6'b000000, 0, 0);
      run(6'b100011, 0, 2);
      run(6'b101011, 0, 0);
      run(6'b000100, 0, 0);
      run(6'b000010, 0, 0);
      run(6'b111111, 0, 0);
      run(6'b001000, 2, 0);
      run(6'b101011, 1, 3);
      run(6'b010001, 0, 0);

      // Reset while a store waits on memory
      cyc(4'd0, 1'b1, rnd_op(), 1'b0, 1'b0);
      cyc(4'd1, 1'b1, 6'b101011, 1'b0, 1'b0);
      cyc(4'd2, 1'b1, 6'b101011, 1'b0, 1'b0);
      cyc(4'd5, 1'b0, rnd_op(), 1'b0, 1'b0);
      reset = 1'b1;
      cyc(4'd5, 1'b0, rnd_op(), 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) run(6'b001000, 0, 0);
      chk("wrap4", {28'b0, b_retiredCount}, 32'd0);
      chk("final32", retiredCount, 32'd16);

      run(6'b000000, 0, 0);
      cyc(4'd0, 1'b0, rnd_op(), 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style main control FSM for the multi-cycle variant of the MIPS datapath. It sequences one instruction over several clock cycles through fetch, decode, execute, memory and writeback, so the ALU and a single unified memory port are shared across steps. Memory accesses stall on a `memReady` handshake. A retired-instruction counter and an illegal-opcode flag support bring-up.

## Interface
Parameters:
- `COUNT_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instruction` in 6: opcode bits [31:26] from the instruction register.
- `memReady` in 1: memory completes the current read or write this cycle.
- `pcWrite` out 1: unconditional PC load.
- `pcWriteCond` out 1: PC load if ALU zero (BEQ).
- `iorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` out 1: memory read request.
- `memWrite` out 1: memory write request.
- `irWrite` out 1: load the instruction register.
- `memToReg` out 1: write-back data select; 1 = MDR, 0 = ALUOut.
- `regDst` out 1: destination register select; 1 = rd, 0 = rt.
- `regWrite` out 1: register-file write enable.
- `aluSrcA` out 1: ALU A input select; 0 = PC, 1 = rs.
- `aluSrcB` out 2: ALU B input select; 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `aluOp` out 2: 0 = none, 1 = funct field, 2 = add, 3 = subtract (existing ALU-control encoding).
- `pcSource` out 2: PC source select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state, for debug.
- `illegalOp` out 1: one-cycle pulse on an undecodable opcode.
- `retiredCount` out COUNT_WIDTH: number of completed instructions.

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, ADDIEXEC=8, ADDIWB=9, BRANCH=10, JUMP=11. Every output not listed for a state is 0.

- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=2, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=2.
  - Next state by `instruction`: 000000→EXECUTE, 001000→ADDIEXEC, 100011 or 101011→MEMADR, 000100→BRANCH, 000010→JUMP.
  - Any other opcode: illegalOp=1 this cycle, then FETCH; not counted as retired.
- MEMADR:
  - Outputs: aluSrcA=1, aluSrcB=10, aluOp=2.
  - Goes to MEMREAD if the opcode is LW, MEMWRITE if SW.
- MEMREAD:
  - Outputs: iorD=1, memRead=1.
  - Holds until memReady=1, then MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1; then FETCH.
- MEMWRITE:
  - Outputs: iorD=1, memWrite=1.
  - Holds until memReady=1, then FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=1; then ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1; then FETCH.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=2; then ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1; then FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=3, pcWriteCond=1, pcSource=01; then FETCH.
- JUMP: pcWrite=1, pcSource=10; then FETCH.
- Retirement: `retiredCount` increments by 1 on the final cycle of each legal instruction.
  - Final cycles are MEMWB, MEMWRITE with memReady=1, ALUWB, ADDIWB, BRANCH and JUMP.
  - The counter wraps modulo 2^COUNT_WIDTH.
- Memory request stability: memRead/memWrite and iorD stay constant while waiting on memReady.

## Timing
- Reset: on the first clock edge with reset=1, state←FETCH and retiredCount←0.
  - While reset=1, all control outputs and illegalOp are forced to 0 combinationally; `state` reads 0.
- Reset mid-operation: any pending memRead/memWrite drops in the same cycle reset is asserted. No partial instruction retires.
- Latency, counted in cycles with memReady=1 at the first opportunity:
  - BEQ and J: 3.
  - R-type, ADDI and SW: 4.
  - LW: 5.
- Each cycle of memReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `instruction` is sampled only in DECODE and MEMADR. The IR does not change outside FETCH.
- memReady is ignored in states that make no memory request.

## Test plan
- Reset, then release with memReady=1 held and opcode 000000.
  - Required: states 0,1,6,7,0.
  - ALUWB shows regDst=1, regWrite=1.
  - retiredCount=1 after 4 cycles.
- LW (100011) with memReady low for 2 cycles in MEMREAD.
  - Required: MEMREAD held 3 cycles with iorD=1, memRead=1 stable.
  - MEMWB shows memToReg=1, regWrite=1.
  - 7 cycles total.
- SW (101011), then BEQ (000100), then J (000010), memReady=1.
  - Required: memWrite=1 exactly 1 cycle.
  - BRANCH shows pcWriteCond=1, aluOp=3, pcSource=01.
  - JUMP shows pcWrite=1, pcSource=10.
  - retiredCount=3 after 10 cycles.
- Opcode 111111 in DECODE.
  - Required: illegalOp=1 for exactly 1 cycle.
  - Next state FETCH; retiredCount unchanged.
- Reset asserted in MEMWRITE while memReady=0.
  - Required: memWrite=0 in the same cycle.
  - state=0 after the edge; retiredCount=0.
- COUNT_WIDTH=4, 16 ADDI (001000) instructions.
  - Required: retiredCount wraps from 15 to 0.
  - ADDIWB shows regDst=0, regWrite=1.
